credit_tx_source: RTL and testbench

- Upstream producer stage of the credit-based CDC buffer; lives entirely in the write (re_clk) domain.
- Owns the credit counter that the buffer relies on.
- Accepts a valid/ready stream from the local datapath and forwards one beat per credit as a registered re_valid/data pair.
- Reclaims one credit per re_credit_pulse returned by the buffer.

---
 rtl/credit_pkg.sv | 28 ++
 rtl/credit_counter.sv | 76 +++++++
 rtl/credit_tx_source.sv | 189 ++++++++++++++++++
 tb/tb_credit_tx_source.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// -----------------------------------------------------------------------------
// credit_pkg
// Shared declarations for the credit-based CDC buffer producer side.
//   credit_tx_state_e : two-state FSM encoding of credit_tx_source
//   DEFAULT_CREDITS   : default credit count, equal to the buffer DEPTH default
//   sat_inc32         : saturating 32-bit increment used by the statistics
// -----------------------------------------------------------------------------
package credit_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } credit_tx_state_e;

  localparam int unsigned DEFAULT_CREDITS = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// -----------------------------------------------------------------------------
// credit_counter
// Up/down counter bounded to [0, MAX] with simultaneous increment/decrement.
// An increment attempted while already at MAX leaves the count unchanged and
// sets a sticky overflow flag (cleared only by reset).
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (count = MAX, ovf = 0)
//   inc_i    : add one (credit returned)
//   dec_i    : subtract one (credit consumed)
//   count_o  : registered current count
//   ovf_o    : registered sticky overflow flag
// -----------------------------------------------------------------------------
module credit_counter
  import credit_pkg::*;
#(
  parameter int unsigned MAX = DEFAULT_CREDITS,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         ovf_q;
  logic         ovf_d;

  // Next-state for count and sticky overflow.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    case ({inc_i, dec_i})
      2'b10: begin
        if (count_q == MAX_C) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + W'(1);
        end
      end
      2'b01: begin
        // The producer never consumes at zero; the guard keeps the count sane anyway.
        if (count_q != '0) begin
          count_d = count_q - W'(1);
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        // Idle or a simultaneous return and consume: the count is unchanged.
        count_d = count_q;
      end
    endcase
  end

  // Count and overflow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= MAX_C;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/credit_tx_source.sv
// -----------------------------------------------------------------------------
// credit_tx_source
// Producer stage of the credit-based CDC buffer, entirely in the re_clk domain.
// Accepts a valid/ready stream and forwards one beat per credit as a registered
// re_valid/data_out pair (latency one cycle). Credits are returned by the
// buffer through re_credit_pulse. After reset the block stays in INIT for
// INIT_WAIT cycles so the far-side synchronizers settle before the first send.
//
// Ports:
//   re_clk          : sole clock
//   re_reset_n      : asynchronous active-low reset
//   in_valid        : upstream beat valid
//   in_data         : upstream beat data
//   in_ready        : beat can be accepted (derived from registers only)
//   re_valid        : one-cycle write strobe to the buffer
//   data_out        : data accompanying re_valid (holds when idle)
//   re_credit_pulse : one-cycle credit return from the buffer
//   credits_avail   : current credit count
//   credit_err      : sticky, credit returned while already full
// Optional (macro CREDIT_TX_STATS_EN):
//   stat_beats      : transfer count, wraps at 2^32
//   stat_stall      : RUN cycles with in_valid at zero credits, saturating
//   stat_min_credit : lowest credits_avail seen since reset
// -----------------------------------------------------------------------------
module credit_tx_source
  import credit_pkg::*;
#(
  parameter int unsigned CREDITS   = DEFAULT_CREDITS,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INIT_WAIT = 4,
  parameter int unsigned CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic             re_clk,
  input  logic             re_reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             re_valid,
  output logic [WIDTH-1:0] data_out,
  input  logic             re_credit_pulse,
  output logic [CNT_W-1:0] credits_avail,
  output logic             credit_err
`ifdef CREDIT_TX_STATS_EN
  ,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_stall,
  output logic [CNT_W-1:0] stat_min_credit
`endif
);

  localparam int unsigned       WAIT_W    = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);

  credit_tx_state_e state_q;
  credit_tx_state_e state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              re_valid_q;
  logic              re_valid_d;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  data_d;

  logic [CNT_W-1:0]  credits_s;
  logic              ovf_s;
  logic              ready_s;
  logic              send_s;

  // Ready depends only on registered state, so there is no path from in_valid
  // or re_credit_pulse to in_ready.
  assign ready_s = (state_q == ST_RUN) && (credits_s != '0);
  assign send_s  = in_valid && ready_s;

  credit_counter #(
    .MAX (CREDITS),
    .W   (CNT_W)
  ) u_credit_counter (
    .clk_i   (re_clk),
    .rst_ni  (re_reset_n),
    .inc_i   (re_credit_pulse),
    .dec_i   (send_s),
    .count_o (credits_s),
    .ovf_o   (ovf_s)
  );

  // FSM next-state: INIT counts settle cycles, RUN is left only by reset.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_INIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        wait_d  = '0;
      end
    endcase
  end

  // FSM state and settle counter registers.
  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      state_q <= ST_INIT;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Output stage next-state: strobe for one cycle per transfer, data holds otherwise.
  always_comb begin
    re_valid_d = send_s;
    if (send_s) begin
      data_d = in_data;
    end else begin
      data_d = data_q;
    end
  end

  // Output stage registers; reset drops any in-flight strobe.
  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      re_valid_q <= 1'b0;
      data_q     <= '0;
    end else begin
      re_valid_q <= re_valid_d;
      data_q     <= data_d;
    end
  end

  assign in_ready      = ready_s;
  assign re_valid      = re_valid_q;
  assign data_out      = data_q;
  assign credits_avail = credits_s;
  assign credit_err    = ovf_s;

`ifdef CREDIT_TX_STATS_EN
  logic [31:0]      stat_beats_q;
  logic [31:0]      stat_beats_d;
  logic [31:0]      stat_stall_q;
  logic [31:0]      stat_stall_d;
  logic [CNT_W-1:0] stat_min_q;
  logic [CNT_W-1:0] stat_min_d;
  logic             stall_s;

  assign stall_s = (state_q == ST_RUN) && in_valid && (credits_s == '0);

  // Statistics next-state.
  always_comb begin
    stat_beats_d = stat_beats_q + {31'd0, send_s};
    if (stall_s) begin
      stat_stall_d = sat_inc32(stat_stall_q);
    end else begin
      stat_stall_d = stat_stall_q;
    end
    if (credits_s < stat_min_q) begin
      stat_min_d = credits_s;
    end else begin
      stat_min_d = stat_min_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      stat_beats_q <= 32'd0;
      stat_stall_q <= 32'd0;
      stat_min_q   <= CNT_W'(CREDITS);
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_stall_q <= stat_stall_d;
      stat_min_q   <= stat_min_d;
    end
  end

  assign stat_beats      = stat_beats_q;
  assign stat_stall      = stat_stall_q;
  assign stat_min_credit = stat_min_q;
`endif

endmodule

// File: tb/tb_credit_tx_source.sv
// -----------------------------------------------------------------------------
// tb_credit_tx_source
// Directed stimulus for credit_tx_source with a cycle-level reference model
// (credit count, cycles since reset, last accepted beat) checked on every
// falling edge, plus literal expectations at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_credit_tx_source;

  localparam int CREDITS   = 16;
  localparam int WIDTH     = 32;
  localparam int INIT_WAIT = 4;
  localparam int CNT_W     = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             re_valid;
  logic [WIDTH-1:0] data_out;
  logic             pulse;
  logic [CNT_W-1:0] credits_avail;
  logic             credit_err;
`ifdef CREDIT_TX_STATS_EN
  logic [31:0]      stat_beats;
  logic [31:0]      stat_stall;
  logic [CNT_W-1:0] stat_min_credit;
`endif

  always #5 clk = ~clk;

  credit_tx_source #(
    .CREDITS   (CREDITS),
    .WIDTH     (WIDTH),
    .INIT_WAIT (INIT_WAIT)
  ) dut (
    .re_clk          (clk),
    .re_reset_n      (rst_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .re_valid        (re_valid),
    .data_out        (data_out),
    .re_credit_pulse (pulse),
    .credits_avail   (credits_avail),
    .credit_err      (credit_err)
`ifdef CREDIT_TX_STATS_EN
    ,
    .stat_beats      (stat_beats),
    .stat_stall      (stat_stall),
    .stat_min_credit (stat_min_credit)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cyc;      // clock edges seen since reset release, capped
  int          m_credits;
  bit          m_err;
  bit          m_valid;
  logic [31:0] m_data;
  logic [31:0] m_beats;
  logic [31:0] m_stall;
  int          m_min;
  logic        m_ready;
  logic        m_send;

  assign m_ready = (m_cyc >= INIT_WAIT) && (m_credits != 0);
  assign m_send  = in_valid && m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc     <= 0;
      m_credits <= CREDITS;
      m_err     <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= 32'd0;
      m_beats   <= 32'd0;
      m_stall   <= 32'd0;
      m_min     <= CREDITS;
    end else begin
      m_valid <= m_send;
      if (m_send) m_data <= in_data;
      if (m_send && !pulse) begin
        m_credits <= m_credits - 1;
      end else if (!m_send && pulse) begin
        if (m_credits == CREDITS) m_err <= 1'b1;
        else m_credits <= m_credits + 1;
      end
      if (m_cyc < INIT_WAIT) m_cyc <= m_cyc + 1;
      m_beats <= m_beats + {31'd0, m_send};
      if ((m_cyc >= INIT_WAIT) && in_valid && (m_credits == 0) && (m_stall != 32'hFFFF_FFFF))
        m_stall <= m_stall + 32'd1;
      if (m_credits < m_min) m_min <= m_credits;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("cmp_in_ready", {63'd0, in_ready}, {63'd0, m_ready});
    chk("cmp_re_valid", {63'd0, re_valid}, {63'd0, m_valid});
    chk("cmp_data_out", {32'd0, data_out}, {32'd0, m_data});
    chk("cmp_credits", {59'd0, credits_avail}, 64'(m_credits));
    chk("cmp_credit_err", {63'd0, credit_err}, {63'd0, m_err});
`ifdef CREDIT_TX_STATS_EN
    chk("cmp_stat_beats", {32'd0, stat_beats}, {32'd0, m_beats});
    chk("cmp_stat_stall", {32'd0, stat_stall}, {32'd0, m_stall});
    chk("cmp_stat_min", {59'd0, stat_min_credit}, 64'(m_min));
`endif
  end

  // Called on the falling edge where reset was just released: counts the
  // cycles with in_ready low, bounded so a stuck DUT still terminates.
  task automatic count_init(output int n);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (in_ready === 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  int n_init;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0000;
    pulse    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_re_valid", {63'd0, re_valid}, 64'd0);
    chk("rst_data_out", {32'd0, data_out}, 64'd0);
    chk("rst_credits", {59'd0, credits_avail}, 64'd16);
    chk("rst_credit_err", {63'd0, credit_err}, 64'd0);

    // INIT lasts exactly 4 cycles; first beat lands one cycle after in_ready.
    rst_n = 1'b1;
    count_init(n_init);
    chk("init_cycles", 64'(n_init), 64'd4);
    @(negedge clk);
    chk("first_re_valid", {63'd0, re_valid}, 64'd1);
    chk("first_data", {32'd0, data_out}, 64'hA5A5_0000);
    chk("first_credits", {59'd0, credits_avail}, 64'd15);
    in_valid = 1'b0;

    // Refill, then 16 back-to-back beats.
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    chk("refill_credits", {59'd0, credits_avail}, 64'd16);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      @(negedge clk);
      chk("b2b_valid", {63'd0, re_valid}, 64'd1);
      chk("b2b_data", {32'd0, data_out}, 64'(i));
    end
    in_data = 32'h0000_0010;
    chk("empty_credits", {59'd0, credits_avail}, 64'd0);
    chk("empty_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (3) @(negedge clk);
    chk("stall_re_valid", {63'd0, re_valid}, 64'd0);
    chk("stall_data_hold", {32'd0, data_out}, 64'h0000_000F);

    // One credit returns: ready the next cycle, beat 17 out two cycles after the pulse.
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    chk("ret_in_ready", {63'd0, in_ready}, 64'd1);
    chk("ret_re_valid", {63'd0, re_valid}, 64'd0);
    chk("ret_credits", {59'd0, credits_avail}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("beat17_valid", {63'd0, re_valid}, 64'd1);
    chk("beat17_data", {32'd0, data_out}, 64'h0000_0010);
    chk("beat17_credits", {59'd0, credits_avail}, 64'd0);

    // Simultaneous send and return at 5 credits.
    pulse = 1'b1;
    repeat (5) @(negedge clk);
    pulse = 1'b0;
    chk("five_credits", {59'd0, credits_avail}, 64'd5);
    in_valid = 1'b1;
    in_data  = 32'h0000_0055;
    pulse    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pulse    = 1'b0;
    chk("simul_credits", {59'd0, credits_avail}, 64'd5);
    chk("simul_valid", {63'd0, re_valid}, 64'd1);

    // Fill up, then one return too many sets the sticky error.
    pulse = 1'b1;
    repeat (11) @(negedge clk);
    pulse = 1'b0;
    chk("full_credits", {59'd0, credits_avail}, 64'd16);
    chk("full_no_err", {63'd0, credit_err}, 64'd0);
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    chk("over_credits", {59'd0, credits_avail}, 64'd16);
    chk("over_err", {63'd0, credit_err}, 64'd1);
    in_valid = 1'b1;
    in_data  = 32'hCAFE_0000;
    repeat (9) @(negedge clk);
    chk("mid_credits", {59'd0, credits_avail}, 64'd7);
    chk("err_sticky", {63'd0, credit_err}, 64'd1);
    chk("mid_valid", {63'd0, re_valid}, 64'd1);

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_re_valid", {63'd0, re_valid}, 64'd0);
    chk("arst_credits", {59'd0, credits_avail}, 64'd16);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("arst_err", {63'd0, credit_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_init(n_init);
    chk("reinit_cycles", 64'(n_init), 64'd4);
    in_valid = 1'b0;
    @(negedge clk);

`ifdef CREDIT_TX_STATS_EN
    // 20 beats offered, 16 on the initial credits, 4 more on late returns.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_WAIT) @(negedge clk);
    chk("stats_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h1000 + 32'(i);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h2000 + 32'(k);
      pulse = 1'b1;
      @(negedge clk);
      pulse = 1'b0;
      repeat (2) @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stat_beats", {32'd0, stat_beats}, 64'd20);
    chk("stat_min", {59'd0, stat_min_credit}, 64'd0);
    chk("stat_stall", {32'd0, stat_stall}, 64'd11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
